gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_sync.sv | 26 ++
 rtl/gpio_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpio_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register index map, error-range
// bound and byte-lane helper.
package gpio_pkg;

    localparam int unsigned MAX_W = 32;

    // Word index of each register (byte offset >> 2)
    typedef enum logic [3:0] {
        REG_OUT      = 4'h0,
        REG_DIR      = 4'h1,
        REG_IN       = 4'h2,
        REG_SET      = 4'h3,
        REG_CLR      = 4'h4,
        REG_TGL      = 4'h5,
        REG_RISE_EN  = 4'h6,
        REG_FALL_EN  = 4'h7,
        REG_IRQ_STAT = 4'h8,
        REG_IRQ_MASK = 4'h9
    } reg_idx_e;

    // Indices from here up to 4'hF (offsets 0x28-0x3C) terminate with err
    localparam logic [3:0] ERR_IDX_FIRST = 4'hA;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous input buses, reset to zero.
module gpio_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Wishbone-classic GPIO controller: output/direction registers, SET/CLR/TGL
// aliases, synchronized inputs and edge-triggered interrupts.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter logic [31:0] RST_OUT = '0,
    localparam int unsigned W      = (WIDTH > MAX_W) ? MAX_W : WIDTH
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    input  logic [W-1:0]  gpio_i,
    output logic [W-1:0]  gpio_o,
    output logic [W-1:0]  gpio_oe_o,
    output logic          irq_o
);

    logic [W-1:0] out_q,  out_d;
    logic [W-1:0] dir_q,  dir_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic [W-1:0] stat_q, stat_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] prev_q, prev_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         irq_q, irq_d;

    logic [W-1:0] in_sync;
    logic [31:0]  bmask32;
    logic [W-1:0] bmask;
    logic [W-1:0] wdat;
    logic [W-1:0] edge_set;
    reg_idx_e     idx;
    logic         is_err;
    logic         start;
    logic         unused_ok;

    gpio_sync #(
        .WIDTH(W)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (gpio_i),
        .q_o   (in_sync)
    );

    assign unused_ok = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, bmask32};

    always_comb begin
        bmask32  = lane_mask(wb_sel_i);
        bmask    = bmask32[W-1:0];
        wdat     = wb_dat_i[W-1:0] & bmask;
        idx      = reg_idx_e'(wb_adr_i[5:2]);
        is_err   = (wb_adr_i[5:2] >= ERR_IDX_FIRST);
        // A pending termination blocks a new start: one access per two cycles
        start    = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
        edge_set = (in_sync & ~prev_q & rise_q) | (~in_sync & prev_q & fall_q);

        out_d   = out_q;
        dir_d   = dir_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        stat_d  = stat_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        prev_d  = in_sync;
        ack_d   = start & ~is_err;
        err_d   = start & is_err;
        irq_d   = |(stat_q & mask_q);

        if (start) begin
            rdata_d = '0;
            if (!is_err) begin
                case (idx)
                    REG_OUT:      rdata_d = 32'(out_q);
                    REG_DIR:      rdata_d = 32'(dir_q);
                    REG_IN:       rdata_d = 32'(in_sync);
                    REG_RISE_EN:  rdata_d = 32'(rise_q);
                    REG_FALL_EN:  rdata_d = 32'(fall_q);
                    REG_IRQ_STAT: rdata_d = 32'(stat_q);
                    REG_IRQ_MASK: rdata_d = 32'(mask_q);
                    default:      rdata_d = '0;
                endcase
                if (wb_we_i) begin
                    case (idx)
                        REG_OUT:      out_d  = (out_q  & ~bmask) | wdat;
                        REG_DIR:      dir_d  = (dir_q  & ~bmask) | wdat;
                        REG_SET:      out_d  = out_q | wdat;
                        REG_CLR:      out_d  = out_q & ~wdat;
                        REG_TGL:      out_d  = out_q ^ wdat;
                        REG_RISE_EN:  rise_d = (rise_q & ~bmask) | wdat;
                        REG_FALL_EN:  fall_d = (fall_q & ~bmask) | wdat;
                        REG_IRQ_STAT: stat_d = stat_q & ~wdat;
                        REG_IRQ_MASK: mask_d = (mask_q & ~bmask) | wdat;
                        default:      ;
                    endcase
                end
            end
        end

        // New edges are applied after the clear so a coincident set wins
        stat_d = stat_d | edge_set;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q   <= RST_OUT[W-1:0];
            dir_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            stat_q  <= '0;
            mask_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            prev_q  <= prev_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    assign wb_dat_o  = rdata_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: an 8-bit instance (RST_OUT=0xA5) and a WIDTH=40 instance
// share one Wishbone bus and pin bus.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [31:0] gpio32;

    logic [31:0] dat8, dat40;
    logic        ack8, err8, irq8, ack40, err40, irq40;
    logic [7:0]  go8, oe8;
    logic [31:0] go40, oe40;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(.WIDTH(8), .RST_OUT(32'h0000_00A5)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_dat_o(dat8), .wb_ack_o(ack8), .wb_err_o(err8),
        .gpio_i(gpio32[7:0]), .gpio_o(go8), .gpio_oe_o(oe8), .irq_o(irq8)
    );

    gpio_ctrl #(.WIDTH(40)) dut40 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_dat_o(dat40), .wb_ack_o(ack40), .wb_err_o(err40),
        .gpio_i(gpio32), .gpio_o(go40), .gpio_oe_o(oe40), .irq_o(irq40)
    );

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        logic [7:0]  out;
        logic [7:0]  oe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic w, logic [7:0] a, logic [31:0] d, logic [3:0] s,
                               logic c, logic [31:0] r, logic e, logic [7:0] o, logic [7:0] oe);
        vec_t x;
        x.we = w; x.adr = a; x.dat = d; x.sel = s; x.chk_rd = c;
        x.rd = r; x.err = e; x.out = o; x.oe = oe;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One access: drive at a falling edge, sample 1ns after the terminating
    // edge, release, then sample again one cycle later (tail must be idle).
    task automatic xfer(input logic wwe, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s,
                        output logic a8, output logic e8, output logic [31:0] r8,
                        output logic a40, output logic e40, output logic [31:0] r40,
                        output logic tail);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wwe; adr = {24'h0, a}; dat = d; sel = s;
        @(posedge clk); #1;
        a8 = ack8; e8 = err8; r8 = dat8; a40 = ack40; e40 = err40; r40 = dat40;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        tail = ack8 | err8 | ack40 | err40;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: index 0 = 8-bit instance, index 1 = 32-bit instance
    logic [31:0] wm [2];
    logic [31:0] m_out[2], m_dir[2], m_rise[2], m_fall[2], m_stat[2], m_mask[2];
    logic [31:0] m_gpio;

    task automatic model_reset();
        wm[0] = 32'h0000_00FF;
        wm[1] = 32'hFFFF_FFFF;
        m_out[0] = 32'hA5; m_out[1] = '0;
        for (int w = 0; w < 2; w++) begin
            m_dir[w] = '0; m_rise[w] = '0; m_fall[w] = '0; m_stat[w] = '0; m_mask[w] = '0;
        end
        m_gpio = '0;
    endtask

    task automatic model_pins(input logic [31:0] nv);
        for (int w = 0; w < 2; w++) begin
            logic [31:0] o, n;
            o = m_gpio & wm[w];
            n = nv & wm[w];
            m_stat[w] = m_stat[w] | (n & ~o & m_rise[w]) | (~n & o & m_fall[w]);
        end
        m_gpio = nv;
    endtask

    task automatic model_xfer(input int w, input logic wwe, input logic [3:0] idx,
                              input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] erd, output logic eerr);
        logic [31:0] bm, wd;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & wm[w];
        wd = d & bm;
        eerr = (idx >= 4'd10);
        erd = '0;
        if (!eerr) begin
            case (idx)
                4'd0: erd = m_out[w];
                4'd1: erd = m_dir[w];
                4'd2: erd = m_gpio & wm[w];
                4'd6: erd = m_rise[w];
                4'd7: erd = m_fall[w];
                4'd8: erd = m_stat[w];
                4'd9: erd = m_mask[w];
                default: erd = '0;
            endcase
            if (wwe) begin
                case (idx)
                    4'd0: m_out[w]  = (m_out[w]  & ~bm) | wd;
                    4'd1: m_dir[w]  = (m_dir[w]  & ~bm) | wd;
                    4'd3: m_out[w]  = m_out[w] | wd;
                    4'd4: m_out[w]  = m_out[w] & ~wd;
                    4'd5: m_out[w]  = m_out[w] ^ wd;
                    4'd6: m_rise[w] = (m_rise[w] & ~bm) | wd;
                    4'd7: m_fall[w] = (m_fall[w] & ~bm) | wd;
                    4'd8: m_stat[w] = m_stat[w] & ~wd;
                    4'd9: m_mask[w] = (m_mask[w] & ~bm) | wd;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic a8, e8, a40, e40, tail;
        logic [31:0] r8, r40;
        int lat;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat = '0; sel = '0; gpio32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack",  {31'b0, ack8}, 32'd0);
        check("rst_err",  {31'b0, err8}, 32'd0);
        check("rst_irq",  {31'b0, irq8}, 32'd0);
        check("rst_dat",  dat8, 32'd0);
        check("rst_out8", {24'b0, go8}, 32'hA5);
        check("rst_oe8",  {24'b0, oe8}, 32'h0);
        check("rst_out40", go40, 32'h0);

        // Table-driven register accesses on the 8-bit instance
        vecs.push_back(v(0, 8'h00, 32'h0,         4'hF, 1, 32'hA5, 0, 8'hA5, 8'h00));
        vecs.push_back(v(0, 8'h04, 32'h0,         4'hF, 1, 32'h00, 0, 8'hA5, 8'h00));
        vecs.push_back(v(0, 8'h20, 32'h0,         4'hF, 1, 32'h00, 0, 8'hA5, 8'h00));
        vecs.push_back(v(1, 8'h00, 32'h0F,        4'hF, 0, 32'h00, 0, 8'h0F, 8'h00));
        vecs.push_back(v(1, 8'h0C, 32'hF0,        4'hE, 0, 32'h00, 0, 8'h0F, 8'h00));
        vecs.push_back(v(1, 8'h0C, 32'hF0,        4'hF, 0, 32'h00, 0, 8'hFF, 8'h00));
        vecs.push_back(v(0, 8'h00, 32'h0,         4'hF, 1, 32'hFF, 0, 8'hFF, 8'h00));
        vecs.push_back(v(1, 8'h10, 32'h0F,        4'hF, 0, 32'h00, 0, 8'hF0, 8'h00));
        vecs.push_back(v(1, 8'h14, 32'hFF,        4'hF, 0, 32'h00, 0, 8'h0F, 8'h00));
        vecs.push_back(v(0, 8'h0C, 32'h0,         4'hF, 1, 32'h00, 0, 8'h0F, 8'h00));
        vecs.push_back(v(1, 8'h30, 32'hFF,        4'hF, 0, 32'h00, 1, 8'h0F, 8'h00));
        vecs.push_back(v(0, 8'h30, 32'h0,         4'hF, 1, 32'h00, 1, 8'h0F, 8'h00));
        vecs.push_back(v(1, 8'h04, 32'h3C,        4'hF, 0, 32'h00, 0, 8'h0F, 8'h3C));
        vecs.push_back(v(0, 8'h04, 32'h0,         4'hF, 1, 32'h3C, 0, 8'h0F, 8'h3C));
        vecs.push_back(v(1, 8'h3C, 32'hFF,        4'hF, 0, 32'h00, 1, 8'h0F, 8'h3C));
        vecs.push_back(v(0, 8'h00, 32'h0,         4'hF, 1, 32'h0F, 0, 8'h0F, 8'h3C));
        vecs.push_back(v(1, 8'h04, 32'h0,         4'hF, 0, 32'h00, 0, 8'h0F, 8'h00));
        vecs.push_back(v(1, 8'h00, 32'h1234_5600, 4'hF, 0, 32'h00, 0, 8'h00, 8'h00));
        vecs.push_back(v(0, 8'h00, 32'h0,         4'hF, 1, 32'h00, 0, 8'h00, 8'h00));

        foreach (vecs[i]) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a8, e8, r8, a40, e40, r40, tail);
            check($sformatf("vec%0d_ack", i), {31'b0, a8}, {31'b0, ~vecs[i].err});
            check($sformatf("vec%0d_err", i), {31'b0, e8}, {31'b0, vecs[i].err});
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), r8, vecs[i].rd);
            check($sformatf("vec%0d_out", i), {24'b0, go8}, {24'b0, vecs[i].out});
            check($sformatf("vec%0d_oe", i),  {24'b0, oe8}, {24'b0, vecs[i].oe});
            check($sformatf("vec%0d_tail", i), {31'b0, tail}, 32'd0);
        end

        // Strobe held high: terminations on alternate edges
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack%0d", i), {31'b0, ack8}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        // Reset during a write: no termination, no side-effect
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat = 32'h55; sel = 4'hF;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", {31'b0, ack8}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 8'h00, 32'h0, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("abort_out", r8, 32'hA5);

        // Rising edge interrupt and W1C
        xfer(1, 8'h18, 32'h01, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        xfer(1, 8'h24, 32'h01, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        @(negedge clk);
        gpio32[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (irq8 && lat == 0) lat = i;
        end
        check("irq_latency", lat, 32'd4);
        xfer(0, 8'h20, 32'h0, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("stat_rise", r8, 32'h01);
        xfer(1, 8'h20, 32'h01, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        @(posedge clk); #1;
        check("irq_cleared", {31'b0, irq8}, 32'd0);

        // Fall on bit 3 lands on the same edge as its W1C: set wins
        @(negedge clk);
        gpio32[3] = 1'b1;
        repeat (4) @(posedge clk);
        xfer(1, 8'h1C, 32'h08, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        @(negedge clk);
        gpio32[3] = 1'b0;
        @(negedge clk);
        xfer(1, 8'h20, 32'h08, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        xfer(0, 8'h20, 32'h0, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("stat_setwins", r8, 32'h08);
        xfer(1, 8'h20, 32'h08, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        xfer(0, 8'h20, 32'h0, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("stat_w1c", r8, 32'h00);

        // WIDTH=40 clamps to 32 functional bits
        xfer(1, 8'h00, 32'hFFFF_FFFF, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("w40_out", go40, 32'hFFFF_FFFF);
        xfer(1, 8'h10, 32'h8000_0001, 4'h9, a8, e8, r8, a40, e40, r40, tail);
        xfer(0, 8'h00, 32'h0, 4'hF, a8, e8, r8, a40, e40, r40, tail);
        check("w40_clr", r40, 32'h7FFF_FFFE);
        check("w8_clr",  r8,  32'h0000_00FE);
        xfer(1, 8'h04, 32'hFFFF_FFFF, 4'h8, a8, e8, r8, a40, e40, r40, tail);
        check("w40_dir", oe40, 32'hFF00_0000);
        check("w8_dir",  {24'b0, oe8}, 32'h0);

        // Randomized accesses against the reference model
        @(negedge clk);
        gpio32 = '0;
        do_reset();
        model_reset();
        for (int it = 0; it < 200; it++) begin
            logic [3:0]  idx, s;
            logic [31:0] d, erd8, erd32;
            logic        wwe, eerr8, eerr32;
            if ($urandom_range(0, 7) == 0) begin
                logic [31:0] nv;
                nv = $urandom;
                model_pins(nv);
                @(negedge clk);
                gpio32 = nv;
                repeat (4) @(posedge clk);
            end
            idx = 4'($urandom_range(0, 15));
            wwe = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            model_xfer(0, wwe, idx, d, s, erd8, eerr8);
            model_xfer(1, wwe, idx, d, s, erd32, eerr32);
            xfer(wwe, {2'($urandom_range(0, 3)), idx, 2'($urandom_range(0, 3))}, d, s,
                 a8, e8, r8, a40, e40, r40, tail);
            check("rnd_err8",  {31'b0, e8},  {31'b0, eerr8});
            check("rnd_ack8",  {31'b0, a8},  {31'b0, ~eerr8});
            check("rnd_err40", {31'b0, e40}, {31'b0, eerr32});
            if (!wwe) begin
                check("rnd_rd8",  r8,  erd8);
                check("rnd_rd40", r40, erd32);
            end
            check("rnd_out8",  {24'b0, go8}, m_out[0]);
            check("rnd_oe8",   {24'b0, oe8}, m_dir[0]);
            check("rnd_out40", go40, m_out[1]);
            check("rnd_oe40",  oe40, m_dir[1]);
            check("rnd_irq8",  {31'b0, irq8},  {31'b0, |(m_stat[0] & m_mask[0])});
            check("rnd_irq40", {31'b0, irq40}, {31'b0, |(m_stat[1] & m_mask[1])});
            check("rnd_tail",  {31'b0, tail}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
